axis_mash11_modulator: RTL
==========================

// Module: axis_mash11_modulator
// PURPOSE
//  AXI-Stream sink for the NCO's signed 16-bit sample stream. Holds each sample for OSR clocks and runs a
//  MASH 1-1 (two cascaded first-order accumulators) delta-sigma modulator. Emits a 2-bit code per clock to
//  the 4-level DAC output stage. Sits between the NCO and the pin driver.
// PARAMETERS
//  DATA_WIDTH  16   input sample width (signed two's complement); also the accumulator width
//  OSR         64   clocks per input sample (oversampling ratio), >= 2
// PORTS
//  aclk             in   1           system clock
//  arst_n           in   1           asynchronous active-low reset
//  enable           in   1           synchronous run enable; low flushes the block to IDLE
//  s_axis_tdata     in   DATA_WIDTH  signed sample
//  s_axis_tvalid    in   1           sample valid
//  s_axis_tready    out  1           sample accepted when tvalid & tready at posedge
//  dac_code         out  2           modulator output code = y + 1, y in {-1,0,1,2}
//  sample_strobe    out  1           1-clock pulse when a new sample enters the modulator
//  underrun         out  1           1-clock pulse: sample boundary reached with no buffered sample
//  underrun_count   out  16          saturating count of underrun pulses, cleared by reset only
// BEHAVIOUR
//  Reset (arst_n low, async): state=IDLE, tick_cnt=0, acc1=acc2=0, c2_d=0, x_cur=0, nxt_valid=0,
//   s_axis_tready=0, dac_code=2'd1, sample_strobe=0, underrun=0, underrun_count=0. All registered outputs.
//  Buffering: one-entry next-sample buffer nxt/nxt_valid. s_axis_tready = enable & ~nxt_valid (registered
//   form allowed if equivalent). Beats with tready low are not consumed.
//  IDLE: accumulators and tick_cnt held at 0, dac_code=1. An accepted beat (cycle T) loads x_cur directly,
//   pulses sample_strobe at T+1, sets state=RUN, and tick_cnt=0 at T+1. The first modulated dac_code
//   appears at T+2.
//  RUN: tick_cnt counts 0..OSR-1 and wraps. Each clock: x_u = x_cur ^ (1<<(DATA_WIDTH-1)), an offset-binary
//   conversion. {c1,s1} = acc1 + x_u; {c2,s2} = acc2 + s1. Both sums are DATA_WIDTH+1 bits with the carry
//   as MSB. Then acc1<=s1, acc2<=s2, c2_d<=c2. y = c1 + c2 - c2_d, and dac_code <= y+1 (range 0..3,
//   never out of range).
//   - At tick_cnt==OSR-1 with nxt_valid: x_cur<=nxt, nxt_valid<=0, sample_strobe=1 next cycle.
//   - At tick_cnt==OSR-1 with ~nxt_valid: x_cur is kept (hold last sample), underrun=1 next cycle, and
//     underrun_count++ saturating at 16'hFFFF.
//   - An accept and a consume of nxt in the same cycle: nxt is consumed into x_cur, the new beat is
//     written to nxt, and nxt_valid stays 1. Not possible with the tready rule above; it is covered for
//     robustness anyway.
//  enable low (either state): next clock state=IDLE, acc1=acc2=c2_d=0, tick_cnt=0, nxt_valid=0
//   (buffered sample dropped), dac_code=1, tready=0. underrun_count is retained.
//  Mean transfer: mean(y) = (tdata + 2^(DATA_WIDTH-1)) / 2^DATA_WIDTH, exact over 2^DATA_WIDTH clocks
//   from zeroed accumulators. Quantisation noise is 2nd-order shaped.
//  Reset mid-operation: immediate return to reset values; no partial sample survives.
// TESTING
//  1 tdata=-32768 held, tvalid=1 -> after first strobe, dac_code==1 every clock; no underrun.
//  2 tdata=0, OSR=65536 (test param) -> sum of (dac_code-1) over 65536 clocks after first update ==
//    32768 exactly.
//  3 tdata=32767 -> every dac_code in 0..3; mean(dac_code-1) over 65536 clocks == 65535/65536 exactly.
//  4 one beat then tvalid=0 -> underrun pulses at OSR-boundary every OSR clocks, underrun_count 1,2,3..;
//    x_cur is held.
//  5 back-to-back beats with OSR=4 -> tready low while nxt full. sample_strobe every 4 clocks. Beats
//    are consumed in order, none lost.
//  6 enable dropped mid-sample with nxt full -> next clock dac_code=1, tready=0, the buffered beat is
//    discarded, and re-enable restarts at IDLE latency (T+2).

Source files
------------

// File: rtl/axis_mash11_modulator.sv
// ============================================================================
// Module      : axis_mash11_modulator
// Description : AXI-Stream sample sink driving a MASH 1-1 delta-sigma modulator
//               that emits a 2-bit code per clock for a 4-level DAC stage.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module axis_mash11_modulator #(
  parameter int DATA_WIDTH = 16,
  parameter int OSR        = 64
) (
  input  logic                  aclk,
  input  logic                  arst_n,
  input  logic                  enable,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata,
  input  logic                  s_axis_tvalid,
  output logic                  s_axis_tready,
  output logic [1:0]            dac_code,
  output logic                  sample_strobe,
  output logic                  underrun,
  output logic [15:0]           underrun_count
);

  localparam int                    TICK_W    = (OSR > 1) ? $clog2(OSR) : 1;
  localparam logic [TICK_W-1:0]     TICK_LAST = TICK_W'(OSR - 1);
  localparam logic [DATA_WIDTH-1:0] SIGN_BIT  = {1'b1, {(DATA_WIDTH-1){1'b0}}};

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t                  state_q, state_d;
  logic [TICK_W-1:0]       tick_q, tick_d;
  logic [DATA_WIDTH-1:0]   acc1_q, acc1_d;
  logic [DATA_WIDTH-1:0]   acc2_q, acc2_d;
  logic                    c2_dly_q, c2_dly_d;
  logic [DATA_WIDTH-1:0]   x_cur_q, x_cur_d;
  logic [DATA_WIDTH-1:0]   nxt_q, nxt_d;
  logic                    nxt_valid_q, nxt_valid_d;
  logic                    tready_q, tready_d;
  logic [1:0]              dac_q, dac_d;
  logic                    strobe_q, strobe_d;
  logic                    underrun_q, underrun_d;
  logic [15:0]             ucnt_q, ucnt_d;

  logic                    accept;
  logic [DATA_WIDTH-1:0]   x_u;
  logic [DATA_WIDTH:0]     sum1;
  logic [DATA_WIDTH:0]     sum2;
  logic [1:0]              dac_mod;
  logic                    boundary;

  assign accept   = s_axis_tvalid & tready_q;
  // Offset-binary view of the signed sample so the accumulators are unsigned.
  assign x_u      = x_cur_q ^ SIGN_BIT;
  assign sum1     = {1'b0, acc1_q} + {1'b0, x_u};
  assign sum2     = {1'b0, acc2_q} + {1'b0, sum1[DATA_WIDTH-1:0]};
  // y + 1 lies in 0..3, so modulo-4 arithmetic gives the exact code.
  assign dac_mod  = {1'b0, sum1[DATA_WIDTH]} + {1'b0, sum2[DATA_WIDTH]} + 2'd1 - {1'b0, c2_dly_q};
  assign boundary = (tick_q == TICK_LAST);

  always_comb begin
    state_d     = state_q;
    tick_d      = tick_q;
    acc1_d      = acc1_q;
    acc2_d      = acc2_q;
    c2_dly_d    = c2_dly_q;
    x_cur_d     = x_cur_q;
    nxt_d       = nxt_q;
    nxt_valid_d = nxt_valid_q;
    dac_d       = dac_q;
    strobe_d    = 1'b0;
    underrun_d  = 1'b0;
    ucnt_d      = ucnt_q;

    if (!enable) begin
      state_d     = ST_IDLE;
      tick_d      = '0;
      acc1_d      = '0;
      acc2_d      = '0;
      c2_dly_d    = 1'b0;
      nxt_valid_d = 1'b0;
      dac_d       = 2'd1;
    end else begin
      case (state_q)
        ST_IDLE: begin
          tick_d   = '0;
          acc1_d   = '0;
          acc2_d   = '0;
          c2_dly_d = 1'b0;
          dac_d    = 2'd1;
          if (accept) begin
            x_cur_d  = s_axis_tdata;
            strobe_d = 1'b1;
            state_d  = ST_RUN;
          end
        end
        ST_RUN: begin
          acc1_d   = sum1[DATA_WIDTH-1:0];
          acc2_d   = sum2[DATA_WIDTH-1:0];
          c2_dly_d = sum2[DATA_WIDTH];
          dac_d    = dac_mod;
          tick_d   = boundary ? '0 : tick_q + TICK_W'(1);
          if (boundary) begin
            if (nxt_valid_q) begin
              x_cur_d     = nxt_q;
              nxt_valid_d = 1'b0;
              strobe_d    = 1'b1;
            end else begin
              underrun_d = 1'b1;
              ucnt_d     = (ucnt_q == 16'hFFFF) ? ucnt_q : ucnt_q + 16'd1;
            end
          end
          // A fresh beat overrides the consume so nxt_valid stays set.
          if (accept) begin
            nxt_d       = s_axis_tdata;
            nxt_valid_d = 1'b1;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end

    tready_d = enable & ~nxt_valid_d;
  end

  always_ff @(posedge aclk or negedge arst_n) begin
    if (!arst_n) begin
      state_q     <= ST_IDLE;
      tick_q      <= '0;
      acc1_q      <= '0;
      acc2_q      <= '0;
      c2_dly_q    <= 1'b0;
      x_cur_q     <= '0;
      nxt_q       <= '0;
      nxt_valid_q <= 1'b0;
      tready_q    <= 1'b0;
      dac_q       <= 2'd1;
      strobe_q    <= 1'b0;
      underrun_q  <= 1'b0;
      ucnt_q      <= '0;
    end else begin
      state_q     <= state_d;
      tick_q      <= tick_d;
      acc1_q      <= acc1_d;
      acc2_q      <= acc2_d;
      c2_dly_q    <= c2_dly_d;
      x_cur_q     <= x_cur_d;
      nxt_q       <= nxt_d;
      nxt_valid_q <= nxt_valid_d;
      tready_q    <= tready_d;
      dac_q       <= dac_d;
      strobe_q    <= strobe_d;
      underrun_q  <= underrun_d;
      ucnt_q      <= ucnt_d;
    end
  end

  assign s_axis_tready  = tready_q;
  assign dac_code       = dac_q;
  assign sample_strobe  = strobe_q;
  assign underrun       = underrun_q;
  assign underrun_count = ucnt_q;

endmodule

`default_nettype wire
